// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] R15_OFFSET = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshakes of the fetch stage.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc, id_pc_plus8,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc, id_pc_plus8,
    output id_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue between instruction memory and decode.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t slot [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign head   = slot[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= wdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem requests, 2-entry buffer to decode.
//   state | meaning
//   REQ   | may request pc; idle when buffer plus in-flight would exceed depth
//   WAIT  | request accepted, response will be pushed into the buffer
//   DROP  | request accepted before a redirect, response is discarded
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  issued_pc, issued_pc_nxt;
  logic         run;
  logic         req;
  logic         push;
  logic         pop;
  logic         flush;
  logic         buf_full;
  logic         buf_empty;
  logic [1:0]   buf_count;
  fetch_entry_t head;
  fetch_entry_t push_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      issued_pc <= '0;
      run       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      issued_pc <= issued_pc_nxt;
      run       <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    issued_pc_nxt = issued_pc;
    req           = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;

    case (state)
      REQ: begin
        req = run && (buf_count < DEPTH);
        if (req && bus.imem_ack) begin
          state_nxt     = WAIT;
          issued_pc_nxt = pc;
          pc_nxt        = pc + PC_STEP;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push      = 1'b1;
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase

    // Anything still in flight after this edge belongs to the old path.
    if (branch_taken) begin
      flush     = 1'b1;
      push      = 1'b0;
      pc_nxt    = word_align(branch_target);
      state_nxt = (state_nxt == REQ) ? REQ : DROP;
    end
  end

  assign pop       = bus.id_ready && !buf_empty;
  assign push_data = '{pc: issued_pc, instr: bus.imem_rdata};

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_data),
    .head  (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.id_valid    = !buf_empty;
  assign bus.id_instr    = buf_empty ? '0 : head.instr;
  assign bus.id_pc       = buf_empty ? '0 : head.pc;
  assign bus.id_pc_plus8 = buf_empty ? '0 : head.pc + R15_OFFSET;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && buf_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] plus8;
    logic [31:0] instr;
  } hs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  fetch_unit_if fif ();
  fetch_unit_if fif2 ();

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (fif.master),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .bus           (fif2.master),
    .branch_taken  (1'b0),
    .branch_target (32'h0)
  );

  int errors = 0;
  int checks = 0;

  // reference model: what the stage holds, as plain queues
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_out_pc;
  bit           m_out;
  bit           m_drop;
  bit           m_run;

  // memory model for the main instance
  bit           mem_pend;
  logic [31:0]  mem_addr;
  int           mem_cnt;
  // memory model for the wrap instance
  bit           pend2;
  logic [31:0]  addr2;

  int           k_ack;
  int           k_ready;
  int           k_lat_min;
  int           k_lat_max;
  bit           k_spur;
  bit           k_br;
  bit           k_rst;
  logic [31:0]  k_tgt;

  hs_t          hs_q[$];
  logic [31:0]  ack_q[$];
  logic [31:0]  ack2_q[$];

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0;
    m_out_pc = 32'h0;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    m_run    = 1'b0;
  endtask

  task automatic model_update(input bit r, input bit acc, input bit rv, input logic [31:0] rd,
                              input bit br, input logic [31:0] tgt, input bit rdy);
    bit resp;
    resp = m_out && rv;
    if (!r) begin
      model_reset();
      return;
    end
    if (br) begin
      m_q.delete();
      m_pc = {tgt[31:2], 2'b00};
      if (acc) begin
        m_out  = 1'b1;
        m_drop = 1'b1;
      end else if (resp) begin
        m_out = 1'b0;
      end else if (m_out) begin
        m_drop = 1'b1;
      end
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (resp) begin
        if (!m_drop) m_q.push_back('{pc: m_out_pc, instr: rd});
        m_out = 1'b0;
      end
      if (acc) begin
        m_out    = 1'b1;
        m_drop   = 1'b0;
        m_out_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
  endtask

  task automatic check_outputs();
    bit er;
    er = m_run && !m_out && (m_q.size() < 2);
    chk_val("imem_req", 32'(fif.imem_req), 32'(er));
    if (er) chk_val("imem_addr", fif.imem_addr, m_pc);
    chk_val("id_valid", 32'(fif.id_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk_val("id_pc", fif.id_pc, m_q[0].pc);
      chk_val("id_instr", fif.id_instr, m_q[0].instr);
      chk_val("id_pc_plus8", fif.id_pc_plus8, m_q[0].pc + 32'd8);
    end else begin
      chk_val("id_pc_idle", fif.id_pc, 32'h0);
      chk_val("id_instr_idle", fif.id_instr, 32'h0);
      chk_val("id_pc_plus8_idle", fif.id_pc_plus8, 32'h0);
    end
  endtask

  // One clock: check at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle();
    bit          a, rv, rdy, br, er, a2;
    logic [31:0] rd, tgt, rd2;
    @(negedge clk);
    check_outputs();
    er  = m_run && !m_out && (m_q.size() < 2);
    br  = k_br;
    tgt = k_tgt;
    k_br = 1'b0;
    rdy = (k_ready == 2) ? ($urandom_range(0, 1) == 1) : (k_ready != 0);

    rv = 1'b0;
    rd = $urandom;
    if (!k_rst) begin
      mem_pend = 1'b0;
      rv = k_spur && ($urandom_range(0, 1) == 1);
    end else if (mem_pend) begin
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = 32'hE000_0000 + mem_addr;
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else begin
      rv = k_spur && ($urandom_range(0, 3) == 0);
    end
    a = k_rst && fif.imem_req && (k_ack == 1 || (k_ack == 2 && $urandom_range(0, 2) != 0));
    if (a) begin
      mem_pend = 1'b1;
      mem_addr = fif.imem_addr;
      mem_cnt  = int'($urandom_range(k_lat_min, k_lat_max)) - 1;
      ack_q.push_back(fif.imem_addr);
    end
    if (k_rst && !br && rdy && fif.id_valid)
      hs_q.push_back('{pc: fif.id_pc, plus8: fif.id_pc_plus8, instr: fif.id_instr});

    rd2 = 32'hE000_0000 + addr2;
    a2  = k_rst && fif2.imem_req;
    fif2.imem_rvalid = pend2;
    fif2.imem_rdata  = rd2;
    fif2.imem_ack    = a2;
    fif2.id_ready    = 1'b0;
    if (!k_rst) begin
      pend2 = 1'b0;
      ack2_q.delete();
    end else begin
      pend2 = a2;
      if (a2) begin
        addr2 = fif2.imem_addr;
        ack2_q.push_back(fif2.imem_addr);
      end
    end

    rst              = k_rst;
    branch_taken     = br;
    branch_target    = tgt;
    fif.imem_ack     = a;
    fif.imem_rvalid  = rv;
    fif.imem_rdata   = rd;
    fif.id_ready     = rdy;
    model_update(k_rst, a && er, rv, rd, br, tgt, rdy);
  endtask

  task automatic do_reset();
    k_rst  = 1'b0;
    k_spur = 1'b1;
    cycle();
    repeat (2) begin
      cycle();
      chk_val("rst_req", 32'(fif.imem_req), 32'h0);
      chk_val("rst_valid", 32'(fif.id_valid), 32'h0);
    end
    k_rst  = 1'b1;
    k_spur = 1'b0;
    cycle();
    chk_val("rel_req", 32'(fif.imem_req), 32'h0);
    cycle();
    chk_val("first_req", 32'(fif.imem_req), 32'h1);
    chk_val("first_addr", fif.imem_addr, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fif.imem_ack = 1'b0; fif.imem_rvalid = 1'b0; fif.imem_rdata = '0; fif.id_ready = 1'b0;
    fif2.imem_ack = 1'b0; fif2.imem_rvalid = 1'b0; fif2.imem_rdata = '0; fif2.id_ready = 1'b0;
    k_ack = 1; k_ready = 1; k_lat_min = 1; k_lat_max = 1;
    k_spur = 1'b0; k_br = 1'b0; k_rst = 1'b0; k_tgt = '0;
    mem_pend = 1'b0; mem_addr = '0; mem_cnt = 0;
    pend2 = 1'b0; addr2 = '0;
    model_reset();
    @(posedge clk);

    // streaming: immediate ack, one-cycle response, decode always ready
    do_reset();
    hs_q.delete();
    repeat (12) cycle();
    chk_val("stream_n", 32'(hs_q.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < hs_q.size(); i++) begin
      chk_val("stream_pc", hs_q[i].pc, 32'(4 * i));
      chk_val("stream_plus8", hs_q[i].plus8, 32'(4 * i + 8));
      chk_val("stream_instr", hs_q[i].instr, 32'hE000_0000 + 32'(4 * i));
    end

    // wrap-around instance has been running alongside with decode stalled
    chk_val("wrap_n", 32'(ack2_q.size()), 32'h2);
    if (ack2_q.size() >= 2) begin
      chk_val("wrap_addr0", ack2_q[0], 32'hFFFF_FFFC);
      chk_val("wrap_addr1", ack2_q[1], 32'h0000_0000);
    end
    chk_val("wrap_valid", 32'(fif2.id_valid), 32'h1);
    chk_val("wrap_pc", fif2.id_pc, 32'hFFFF_FFFC);
    chk_val("wrap_plus8", fif2.id_pc_plus8, 32'h0000_0004);
    chk_val("wrap_instr", fif2.id_instr, 32'hDFFF_FFFC);

    // backpressure, then redirect with a request outstanding
    k_ready = 0;
    do_reset();
    repeat (6) cycle();
    repeat (4) begin
      cycle();
      chk_val("bp_req", 32'(fif.imem_req), 32'h0);
      chk_val("bp_head", fif.id_pc, 32'h0);
    end
    k_lat_min = 4; k_lat_max = 4;
    k_ready = 1;
    ack_q.delete();
    cycle();
    k_ready = 0;
    repeat (2) cycle();
    chk_val("one_req_n", 32'(ack_q.size()), 32'h1);
    if (ack_q.size() > 0) chk_val("one_req_addr", ack_q[0], 32'h8);
    k_br = 1'b1; k_tgt = 32'h0000_0103;
    k_lat_min = 1; k_lat_max = 1;
    ack_q.delete();
    hs_q.delete();
    cycle();
    cycle();
    chk_val("rd_flush_valid", 32'(fif.id_valid), 32'h0);
    k_ready = 1;
    for (int i = 0; i < 20 && hs_q.size() == 0; i++) cycle();
    chk_val("rd_hs_seen", 32'(hs_q.size() != 0), 32'h1);
    if (hs_q.size() != 0) begin
      chk_val("rd_pc", hs_q[0].pc, 32'h100);
      chk_val("rd_plus8", hs_q[0].plus8, 32'h108);
      chk_val("rd_instr", hs_q[0].instr, 32'hE000_0100);
    end
    if (ack_q.size() != 0) chk_val("rd_addr", ack_q[0], 32'h100);
    else chk_val("rd_addr_seen", 32'(ack_q.size()), 32'h1);

    // push, pop and redirect all in one cycle
    k_ready = 0; k_lat_min = 2; k_lat_max = 2;
    do_reset();
    repeat (4) cycle();
    k_ready = 1; k_br = 1'b1; k_tgt = 32'h0000_0200;
    hs_q.delete();
    cycle();
    cycle();
    chk_val("sim_flush_valid", 32'(fif.id_valid), 32'h0);
    chk_val("sim_new_req", 32'(fif.imem_req), 32'h1);
    chk_val("sim_new_addr", fif.imem_addr, 32'h200);
    repeat (16) cycle();
    chk_val("sim_hs_n", 32'(hs_q.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < hs_q.size(); i++)
      chk_val("sim_pc", hs_q[i].pc, 32'h200 + 32'(4 * i));

    // random traffic with redirects, spurious responses and occasional resets
    k_ack = 2; k_ready = 2; k_lat_min = 1; k_lat_max = 3; k_spur = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        k_br  = 1'b1;
        k_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      k_rst = ($urandom_range(0, 299) != 0);
      cycle();
    end
    k_rst = 1'b1; k_spur = 1'b0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and the register file.
- Holds the PC and issues word requests to instruction memory with a single-outstanding request/ack/response protocol.
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Supplies the PC+8 value that the register file returns for R15 reads. Handles branch redirect from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; only the value 2 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word address of request, bits[1:0] always 0.
- imem_ack  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  response data valid, in order, at least 1 cycle after ack.
- imem_rdata  in  32  instruction word.
- branch_taken  in  1  redirect from execute.
- branch_target  in  32  redirect address.
- id_valid  out  1  buffer head valid.
- id_ready  in  1  decode accepts the head.
- id_instr  out  32  head instruction.
- id_pc  out  32  head instruction address.
- id_pc_plus8  out  32  id_pc+8, drives register file R15.

Behaviour:
- Reset values: pc=RESET_PC, imem_req=0, id_valid=0, buffer empty, state=REQ, outstanding=0. id_instr, id_pc and id_pc_plus8 are 0.
- First request is issued the cycle after rst returns to 1.
- State machine:
  - REQ: imem_req=1 when (occupancy + outstanding) < BUF_DEPTH. On imem_ack, go to WAIT and set pc+=4.
  - WAIT: imem_req=0. On imem_rvalid, push {issued pc, rdata} and go to REQ.
  - DROP: imem_req=0. On imem_rvalid, discard the data and go to REQ.
- Request hold: imem_req and imem_addr stay stable until imem_ack, except after a redirect, which retargets the address.
- Redirect (branch_taken=1), highest priority:
  - Flush the buffer and set pc = {branch_target[31:2], 2'b00}.
  - If a response is outstanding, go to DROP; otherwise go to REQ.
  - An id_valid/id_ready handshake in the redirect cycle is void; decode squashes it.
  - A redirect while in DROP stays in DROP with the new pc.
- Latency:
  - imem_rvalid to id_valid is 1 cycle; there is no bypass.
  - Redirect to new imem_req is 1 cycle if nothing is outstanding.
- Buffer:
  - A pop occurs on id_valid & id_ready.
  - Push and pop in the same cycle are legal.
  - Overflow is impossible by the issue rule. A push with the buffer full is an assertion failure.
- id_valid = buffer not empty.
- id_pc_plus8 = id_pc + 8, modulo 2^32.
- PC increments modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- imem_rvalid with no outstanding request is ignored. This covers in-flight responses cancelled by reset, since memory shares rst.
- Reset mid-operation returns every register to its reset value in the same edge.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DROP}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Constants PC_STEP=4 and R15_OFFSET=8.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, full, empty and count. Synchronous active-low rst.

Test Plan:
- Reset: hold rst=0 for 3 cycles, with random rvalid -> imem_req=0 and id_valid=0 throughout. Release -> next cycle imem_req=1, imem_addr=0x0.
- Streaming: ack immediately, rvalid 1 cycle later with rdata=0xE000_0000+addr, id_ready=1 -> id_pc sequence 0x0, 0x4, 0x8 and id_pc_plus8 sequence 0x8, 0xC, 0x10, with matching id_instr.
- Backpressure: id_ready=0 -> after 2 entries buffered, imem_req=0 and stays 0. One pop -> exactly one new request to 0x8.
- Redirect while outstanding: request to 0x8 acked, branch_taken with target 0x103 before rvalid -> that response is dropped, next imem_addr=0x100, first id_pc=0x100, id_pc_plus8=0x108, buffer previously holding 0x0/0x4 is empty.
- Simultaneous push/pop and redirect with handshake: id_ready=1, rvalid=1 and branch_taken=1 in one cycle -> buffer empty next cycle, no entry with the old pc ever presented again.
- Wrap-around: RESET_PC=0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0. id_pc_plus8 for the first entry = 0x0000_0004.
